// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared stage and instruction-type codes for the multi-cycle CPU stage sequencer.
// Stage encodings match the STG_* codes of the shared architecture definitions.
package cpu_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    STG_FETCH = 3'd0,
    STG_EXEC  = 3'd1,
    STG_MEM   = 3'd2,
    STG_WB    = 3'd3,
    STG_PCUPD = 3'd4,
    STG_HALT  = 3'd5,
    STG_ERR   = 3'd6
  } stage_e;

  // Decoded instruction-type codes shared with the decoder.
  localparam int unsigned ITYPE_ALU      = 0;
  localparam int unsigned ITYPE_LOAD_MEM = 1;
  localparam int unsigned ITYPE_STORE    = 2;
  localparam int unsigned ITYPE_JUMP     = 3;
  localparam int unsigned ITYPE_HALT     = 4;

endpackage

// File: rtl/cpu_stage_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged request cycles and flags when TIMEOUT_CYC is reached.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Any cycle without a pending unacked request restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run && !timeout) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout = (cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Variable-length stage controller for the multi-cycle CPU with req/ack memory handshake.
// Optional performance counters are built when CPU_SEQ_PERF_EN is defined.
module cpu_stage_sequencer
  import cpu_stage_sequencer_pkg::*;
#(
  parameter int unsigned ITYPE_W     = 5,
  parameter int unsigned TIMEOUT_CYC = 16
`ifdef CPU_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ITYPE_W-1:0] instr_type,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_is_fetch,
  output logic               mem_we,
  output logic               issue_en,
  output logic               reg_we,
  output logic               pc_en,
  output logic [2:0]         stage,
  output logic               halted,
  output logic               bus_error
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retired_cnt
`endif
);

  localparam logic [ITYPE_W-1:0] IT_LOAD  = ITYPE_W'(ITYPE_LOAD_MEM);
  localparam logic [ITYPE_W-1:0] IT_STORE = ITYPE_W'(ITYPE_STORE);
  localparam logic [ITYPE_W-1:0] IT_JUMP  = ITYPE_W'(ITYPE_JUMP);
  localparam logic [ITYPE_W-1:0] IT_HALT  = ITYPE_W'(ITYPE_HALT);

  stage_e state, state_next;
  logic   act;
  logic   timeout;
  logic   is_store;

  // Gating with rst lets requests and enables fall as soon as reset asserts.
  assign act      = ~rst;
  assign is_store = (instr_type == IT_STORE);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (mem_req && !mem_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STG_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_is_fetch = 1'b0;
    mem_we       = 1'b0;
    issue_en     = 1'b0;
    reg_we       = 1'b0;
    pc_en        = 1'b0;
    unique case (state)
      STG_FETCH: begin
        mem_req      = act;
        mem_is_fetch = act;
        if (act && mem_ack) begin
          issue_en   = 1'b1;
          state_next = STG_EXEC;
        end else if (timeout) begin
          state_next = STG_ERR;
        end
      end
      STG_EXEC: begin
        if (instr_type == IT_LOAD || instr_type == IT_STORE) begin
          state_next = STG_MEM;
        end else if (instr_type == IT_JUMP) begin
          state_next = STG_PCUPD;
        end else if (instr_type == IT_HALT) begin
          state_next = STG_HALT;
        end else begin
          state_next = STG_WB;
        end
      end
      STG_MEM: begin
        mem_req = act;
        mem_we  = act && is_store;
        if (act && mem_ack) begin
          state_next = is_store ? STG_PCUPD : STG_WB;
        end else if (timeout) begin
          state_next = STG_ERR;
        end
      end
      STG_WB: begin
        reg_we     = act;
        state_next = STG_PCUPD;
      end
      STG_PCUPD: begin
        pc_en      = act;
        state_next = STG_FETCH;
      end
      STG_HALT:  state_next = STG_HALT;
      STG_ERR:   state_next = STG_ERR;
      default:   state_next = STG_ERR;
    endcase
  end

  assign stage     = state;
  assign halted    = (state == STG_HALT);
  assign bus_error = (state == STG_ERR);

`ifdef CPU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (state != STG_HALT && state != STG_ERR) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_en) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed self-checking bench for cpu_stage_sequencer (TIMEOUT_CYC=4); CPU_SEQ_PERF_EN adds counter checks.
module tb_cpu_stage_sequencer;
  import cpu_stage_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] instr_type = 5'(ITYPE_ALU);
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_is_fetch, mem_we, issue_en, reg_we, pc_en, halted, bus_error;
  logic [2:0] stage;
`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_stage_sequencer #(
    .ITYPE_W     (5),
    .TIMEOUT_CYC (4)
`ifdef CPU_SEQ_PERF_EN
    ,
    .CNT_W       (32)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_type   (instr_type),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_is_fetch (mem_is_fetch),
    .mem_we       (mem_we),
    .issue_en     (issue_en),
    .reg_we       (reg_we),
    .pc_en        (pc_en),
    .stage        (stage),
    .halted       (halted),
    .bus_error    (bus_error)
`ifdef CPU_SEQ_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .retired_cnt  (retired_cnt)
`endif
  );

  // Observed vector: stage, then req, fetch, we, issue, reg_we, pc_en, halted, bus_error.
  logic [10:0] obs;
  assign obs = {stage, mem_req, mem_is_fetch, mem_we, issue_en, reg_we, pc_en, halted, bus_error};

  localparam logic [10:0] V_RST   = {3'd0, 8'b0000_0000};
  localparam logic [10:0] V_FWAIT = {3'd0, 8'b1100_0000};
  localparam logic [10:0] V_FACK  = {3'd0, 8'b1101_0000};
  localparam logic [10:0] V_EXEC  = {3'd1, 8'b0000_0000};
  localparam logic [10:0] V_MLD   = {3'd2, 8'b1000_0000};
  localparam logic [10:0] V_MST   = {3'd2, 8'b1010_0000};
  localparam logic [10:0] V_WB    = {3'd3, 8'b0000_1000};
  localparam logic [10:0] V_PC    = {3'd4, 8'b0000_0100};
  localparam logic [10:0] V_HALT  = {3'd5, 8'b0000_0010};
  localparam logic [10:0] V_ERR   = {3'd6, 8'b0000_0001};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive ack mid-cycle, then check the combinational outputs.
  task automatic cyc(input logic ack, input string tag, input logic [10:0] exp);
    @(negedge clk);
    rst     = 1'b0;
    mem_ack = ack;
    #1;
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("reset", 64'(obs), 64'(V_RST));
  endtask

  initial begin
    // Zero-wait ALU: F,E,W,P then back to F
    do_reset();
    instr_type = 5'(ITYPE_ALU);
    cyc(1'b1, "alu_fetch", V_FACK);
    cyc(1'b1, "alu_exec",  V_EXEC);
    cyc(1'b1, "alu_wb",    V_WB);
    cyc(1'b1, "alu_pcupd", V_PC);
    cyc(1'b1, "alu_next",  V_FACK);

    // Load: fetch ack after 3 waits, MEM ack after 2 waits
    do_reset();
    instr_type = 5'(ITYPE_LOAD_MEM);
    cyc(1'b0, "ld_f1", V_FWAIT);
    cyc(1'b0, "ld_f2", V_FWAIT);
    cyc(1'b0, "ld_f3", V_FWAIT);
    cyc(1'b1, "ld_f4", V_FACK);
    cyc(1'b0, "ld_exec", V_EXEC);
    cyc(1'b0, "ld_m1", V_MLD);
    cyc(1'b0, "ld_m2", V_MLD);
    cyc(1'b1, "ld_m3", V_MLD);
    cyc(1'b1, "ld_wb", V_WB);
    cyc(1'b1, "ld_pcupd", V_PC);
    cyc(1'b1, "ld_next", V_FACK);

    // Store then jump, zero-wait
    do_reset();
    instr_type = 5'(ITYPE_STORE);
    cyc(1'b1, "st_fetch", V_FACK);
    cyc(1'b1, "st_exec",  V_EXEC);
    cyc(1'b1, "st_mem",   V_MST);
    cyc(1'b1, "st_pcupd", V_PC);
    instr_type = 5'(ITYPE_JUMP);
    cyc(1'b1, "jmp_fetch", V_FACK);
    cyc(1'b1, "jmp_exec",  V_EXEC);
    cyc(1'b1, "jmp_pcupd", V_PC);
    cyc(1'b1, "jmp_next",  V_FACK);

    // Fetch timeout: 5 unacked FETCH cycles, then ERR; late ack ignored
    do_reset();
    instr_type = 5'(ITYPE_ALU);
    for (int i = 1; i <= 5; i++) cyc(1'b0, $sformatf("to_f%0d", i), V_FWAIT);
    cyc(1'b0, "to_err", V_ERR);
    cyc(1'b1, "to_err_ack", V_ERR);
    cyc(1'b0, "to_err_stay", V_ERR);

    // Ack on the 4th fetch cycle: no error
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b0, $sformatf("ok4_f%0d", i), V_FWAIT);
    cyc(1'b1, "ok4_f4", V_FACK);
    cyc(1'b1, "ok4_exec", V_EXEC);

    // Ack on the 5th cycle (counter at limit) wins; then MEM timeout
    do_reset();
    instr_type = 5'(ITYPE_LOAD_MEM);
    for (int i = 1; i <= 4; i++) cyc(1'b0, $sformatf("ok5_f%0d", i), V_FWAIT);
    cyc(1'b1, "ok5_f5", V_FACK);
    cyc(1'b0, "ok5_exec", V_EXEC);
    for (int i = 1; i <= 5; i++) cyc(1'b0, $sformatf("mto_m%0d", i), V_MLD);
    cyc(1'b0, "mto_err", V_ERR);

    // Halt: sticky, no requests or enables even with ack high
    do_reset();
    instr_type = 5'(ITYPE_HALT);
    cyc(1'b1, "hlt_fetch", V_FACK);
    cyc(1'b1, "hlt_exec",  V_EXEC);
    for (int i = 1; i <= 3; i++) cyc(1'b1, $sformatf("hlt_%0d", i), V_HALT);

    // Reset in the middle of a MEM wait drops mem_req immediately
    do_reset();
    instr_type = 5'(ITYPE_LOAD_MEM);
    cyc(1'b1, "rm_fetch", V_FACK);
    cyc(1'b0, "rm_exec",  V_EXEC);
    cyc(1'b0, "rm_m1",    V_MLD);
    cyc(1'b0, "rm_m2",    V_MLD);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rm_async", 64'(obs), 64'(V_RST));
    cyc(1'b1, "rm_restart", V_FACK);
    cyc(1'b1, "rm_exec2",   V_EXEC);

`ifdef CPU_SEQ_PERF_EN
    // Three zero-wait ALU instrs (12 cycles) then halt (F,E): 14 counted cycles
    do_reset();
    instr_type = 5'(ITYPE_ALU);
    chk("perf_cyc0", 64'(cycle_cnt), 64'd0);
    for (int i = 0; i < 12; i++) cyc(1'b1, "perf_run", (i % 4 == 0) ? V_FACK :
                                                         (i % 4 == 1) ? V_EXEC :
                                                         (i % 4 == 2) ? V_WB : V_PC);
    instr_type = 5'(ITYPE_HALT);
    cyc(1'b1, "perf_hf", V_FACK);
    cyc(1'b1, "perf_he", V_EXEC);
    cyc(1'b1, "perf_halt", V_HALT);
    chk("perf_retired", 64'(retired_cnt), 64'd3);
    chk("perf_cycles",  64'(cycle_cnt),   64'd14);
    for (int i = 0; i < 4; i++) cyc(1'b1, "perf_halt_hold", V_HALT);
    chk("perf_cycles_frozen", 64'(cycle_cnt), 64'd14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
